// File: rtl/sar_ota_ctrl_if.sv
// Converter-side bundle between the SAR controller and its user/analog tile.
// The master side drives enable, start and the raw comparator output; the
// slave side (the controller) returns sample/hold, DAC trial code and status.
interface sar_ota_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             start;
  logic             cmp_in;
  logic             sample;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output ena, start, cmp_in,
    input  sample, dac_code, busy, done, result
  );

  modport slave (
    input  ena, start, cmp_in,
    output sample, dac_code, busy, done, result
  );
endinterface

// File: rtl/sar_ota_ctrl.sv
// Successive-approximation controller: samples the input, then runs an
// MSB-first binary search by driving trial codes into the DAC and reading
// the synchronised OTA comparator decision back. All outputs are registered.
module sar_ota_ctrl #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE     = 4
) (
  input logic           clk,
  input logic           rst_n,
  sar_ota_ctrl_if.slave bus
);
  localparam int               IW        = $clog2(WIDTH);
  localparam int               CW        = 16;
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MSB       = ONE << (WIDTH - 1);
  localparam logic [IW-1:0]    TOP_IDX   = IW'(WIDTH - 1);
  localparam logic [CW-1:0]    SAMPLE_LD = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    TRIAL  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             cmp_meta_q, cmp_s_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Current trial bit, the following (lower) trial bit, and acc with the
  // current decision folded in. next_mask_s is only consumed while idx_q > 0.
  logic [WIDTH-1:0] bit_mask_s, next_mask_s, acc_dec_s;
  assign bit_mask_s  = ONE << idx_q;
  assign next_mask_s = ONE << (idx_q - IW'(1));
  assign acc_dec_s   = acc_q | (cmp_s_q ? bit_mask_s : ZERO);

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= bus.cmp_in;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      idx_q    <= {IW{1'b0}};
      acc_q    <= ZERO;
      dac_q    <= ZERO;
      result_q <= ZERO;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; ena low forces an abort to IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    dac_d    = dac_q;
    result_d = result_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (!bus.ena) begin
      state_d  = IDLE;
      sample_d = 1'b0;
      busy_d   = 1'b0;
      dac_d    = ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d  = SAMPLE;
            cnt_d    = SAMPLE_LD;
            sample_d = 1'b1;
            busy_d   = 1'b1;
            dac_d    = ZERO;
          end else begin
            sample_d = 1'b0;
            busy_d   = 1'b0;
            dac_d    = ZERO;
          end
        end
        SAMPLE: begin
          if (cnt_q == {CW{1'b0}}) begin
            state_d  = TRIAL;
            sample_d = 1'b0;
            acc_d    = ZERO;
            idx_d    = TOP_IDX;
            dac_d    = MSB;
            cnt_d    = SETTLE_LD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        TRIAL: begin
          if (cnt_q == {CW{1'b0}}) begin
            acc_d = acc_dec_s;
            if (idx_q == {IW{1'b0}}) begin
              state_d  = DONE;
              result_d = acc_dec_s;
              dac_d    = acc_dec_s;
              done_d   = 1'b1;
            end else begin
              idx_d = idx_q - IW'(1);
              dac_d = acc_dec_s | next_mask_s;
              cnt_d = SETTLE_LD;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          dac_d   = ZERO;
        end
        default: begin
          state_d  = IDLE;
          sample_d = 1'b0;
          busy_d   = 1'b0;
          dac_d    = ZERO;
        end
      endcase
    end
  end

  assign bus.sample   = sample_q;
  assign bus.dac_code = dac_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
endmodule

// File: tb/tb_sar_ota_ctrl.sv
// Bench for sar_ota_ctrl: ideal and randomised comparator models, a
// binary-search reference computed per cycle, and abort/reset scenarios.
module tb_sar_ota_ctrl;
  localparam int W   = 8;
  localparam int SC  = 4;
  localparam int S   = 4;
  localparam int LAT = SC + W * S;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         use_rnd = 1'b0;
  logic         rnd_val = 1'b0;
  logic [W-1:0] x_val   = '0;
  logic         hist [0:63];
  logic [W-1:0] exp_result = '0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cur_c    = 0;

  sar_ota_ctrl_if #(.WIDTH(W)) bus ();

  sar_ota_ctrl #(.WIDTH(W), .SAMPLE_CYC(SC), .SETTLE(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Comparator: ideal (X >= DAC level) or a bench-chosen bit per edge.
  assign bus.cmp_in = use_rnd ? rnd_val : (x_val >= bus.dac_code);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s c=%0d: got 0x%0h, expected 0x%0h", tag, cur_c, obs, expv);
    end
  endtask

  // One conversion, entered at a negedge. smode: 0 start pulse, 1 start held,
  // 2 random start during busy. intr: 0 none, 1 ena drop, 2 async reset at intr_c.
  task automatic run_conv(input logic rnd_mode, input logic [W-1:0] x, input int smode,
                          input int intr, input int intr_c);
    logic [W-1:0] code_m;
    logic [W-1:0] trial;
    logic [W-1:0] exp_dac;
    logic         bitv;
    int           j;
    code_m    = '0;
    use_rnd   = rnd_mode;
    x_val     = x;
    hist[0]   = 1'($urandom);
    rnd_val   = hist[0];
    bus.start = 1'b1;
    bus.ena   = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge clk);
      cur_c = c;
      if (c >= SC + S && c <= LAT && ((c - SC) % S) == 0) begin
        j     = (c - SC) / S - 1;
        trial = code_m | (ONE << (W - 1 - j));
        bitv  = rnd_mode ? hist[c-2] : (x >= trial);
        if (bitv) code_m = trial;
      end
      if (c < SC) exp_dac = '0;
      else if (c < LAT) begin
        j       = (c - SC) / S;
        exp_dac = code_m | (ONE << (W - 1 - j));
      end else if (c == LAT) exp_dac = code_m;
      else exp_dac = '0;
      if (c == LAT) exp_result = code_m;
      check_val("sample", 32'(bus.sample), 32'(c < SC));
      check_val("busy",   32'(bus.busy),   32'(c <= LAT));
      check_val("done",   32'(bus.done),   32'(c == LAT));
      check_val("dac",    32'(bus.dac_code), 32'(exp_dac));
      check_val("result", 32'(bus.result),   32'(exp_result));
      if (intr == 1 && c == intr_c) begin
        bus.ena   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        cur_c = c + 1;
        check_val("abort_sample", 32'(bus.sample), 32'd0);
        check_val("abort_busy",   32'(bus.busy),   32'd0);
        check_val("abort_dac",    32'(bus.dac_code), 32'd0);
        check_val("abort_done",   32'(bus.done),   32'd0);
        check_val("abort_result", 32'(bus.result), 32'(exp_result));
        repeat (4) begin
          @(negedge clk);
          check_val("abort_hold_busy", 32'(bus.busy), 32'd0);
          check_val("abort_hold_done", 32'(bus.done), 32'd0);
        end
        bus.ena   = 1'b1;
        bus.start = 1'b0;
        break;
      end
      if (intr == 2 && c == intr_c) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_sample", 32'(bus.sample), 32'd0);
        check_val("rst_busy",   32'(bus.busy),   32'd0);
        check_val("rst_done",   32'(bus.done),   32'd0);
        check_val("rst_dac",    32'(bus.dac_code), 32'd0);
        check_val("rst_result", 32'(bus.result), 32'd0);
        exp_result = '0;
        bus.start  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      // Force a toggle one edge before each decision edge to exercise the synchroniser.
      hist[c+1] = (((c + 2 - SC) % S) == 0) ? ~hist[c] : 1'($urandom);
      rnd_val   = hist[c+1];
      case (smode)
        0:       bus.start = 1'b0;
        1:       bus.start = 1'b1;
        2:       bus.start = (c < LAT - 1) ? 1'($urandom) : 1'b0;
        default: bus.start = 1'b0;
      endcase
    end
  endtask

  // Top-level sequence of scenarios.
  initial begin
    bus.ena   = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    cur_c = -1;
    check_val("reset_sample", 32'(bus.sample), 32'd0);
    check_val("reset_busy",   32'(bus.busy),   32'd0);
    check_val("reset_done",   32'(bus.done),   32'd0);
    check_val("reset_dac",    32'(bus.dac_code), 32'd0);
    check_val("reset_result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(1'b0, 8'hA5, 0, 0, 0);
    run_conv(1'b0, 8'h00, 0, 0, 0);
    run_conv(1'b0, 8'hFF, 0, 0, 0);
    run_conv(1'b0, 8'h3C, 1, 0, 0);
    run_conv(1'b0, 8'h3C, 1, 0, 0);
    run_conv(1'b0, 8'h3C, 2, 0, 0);
    run_conv(1'b0, 8'h3C, 0, 1, 10);
    run_conv(1'b0, 8'h77, 0, 2, 15);
    run_conv(1'b0, 8'h5A, 0, 0, 0);
    repeat (3) run_conv(1'b1, 8'h00, 0, 0, 0);
    repeat (4) run_conv(1'b0, W'($urandom), int'($urandom_range(0, 2)), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
